seven_segment_display_arbiter: RTL and testbench

Shares the single 4-digit seven-segment display between three requesters, for example a status counter, an error code and a debug value. It grants display ownership round-robin, with a guaranteed minimum dwell time per grant. The winner's 16-bit hex word is forwarded on hex_data_bus_o, which connects directly to hex_data_bus_i of hex_to_seven_segments. When no requester is active, a fixed idle pattern is shown.

---
 rtl/seven_segment_display_arbiter.sv | 88 ++++++++
 tb/tb_seven_segment_display_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_display_arbiter.sv
// seven_segment_display_arbiter: round-robin owner of the shared 4-digit hex display with minimum dwell per grant
// Ports:
//   clk50m_i        system clock
//   rst_n_i         asynchronous active-low reset
//   req_i[2:0]      level-sensitive display requests, bit n = source n
//   data0_i..data2_i 16-bit hex words of sources 0..2
//   grant_o[2:0]    one-hot current owner, 0 when idle
//   owner_o[1:0]    index of current owner, 3 when idle
//   hex_data_bus_o  registered word for hex_to_seven_segments
module seven_segment_display_arbiter #(
    parameter int          CLK_FREQ_MHZ = 50,
    parameter int          DWELL_MS     = 500,
    parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
    input  logic        clk50m_i,
    input  logic        rst_n_i,
    input  logic [2:0]  req_i,
    input  logic [15:0] data0_i,
    input  logic [15:0] data1_i,
    input  logic [15:0] data2_i,
    output logic [2:0]  grant_o,
    output logic [1:0]  owner_o,
    output logic [15:0] hex_data_bus_o
);
    localparam int DWELL_CYCLES = CLK_FREQ_MHZ * 1000 * DWELL_MS;
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    last;
    logic [1:0]    s0, s1, s2, win;
    logic [15:0]   win_data, own_data;
    logic          decide;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] i, input logic [15:0] d0,
                                         input logic [15:0] d1, input logic [15:0] d2);
        return (i == 2'd0) ? d0 : (i == 2'd1) ? d1 : d2;
    endfunction

    // Search order last+1, last+2, last. While owning, last is the owner, so
    // the other sources are examined first and the owner itself only last.
    always_comb begin
        s0       = inc3(last);
        s1       = inc3(s0);
        s2       = inc3(s1);
        win      = req_i[s0] ? s0 : req_i[s1] ? s1 : s2;
        win_data = pick(win, data0_i, data1_i, data2_i);
        own_data = pick(last, data0_i, data1_i, data2_i);
        decide   = (state == IDLE) || (cnt == '0);
    end

    always_ff @(posedge clk50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= 2'd2;
            grant_o        <= 3'b000;
            owner_o        <= 2'd3;
            hex_data_bus_o <= IDLE_PATTERN;
        end else if (decide) begin
            if (|req_i) begin
                state          <= OWN;
                cnt            <= RELOAD;
                last           <= win;
                owner_o        <= win;
                grant_o        <= 3'b001 << win;
                hex_data_bus_o <= win_data;
            end else begin
                state          <= IDLE;
                cnt            <= '0;
                grant_o        <= 3'b000;
                owner_o        <= 2'd3;
                hex_data_bus_o <= IDLE_PATTERN;
            end
        end else begin
            cnt <= cnt - CW'(1);
            // A dropped owner request freezes the display until the dwell ends.
            if (req_i[last]) hex_data_bus_o <= own_data;
        end
    end
endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// tb_seven_segment_display_arbiter: scoreboard bench for the display arbiter
module tb_seven_segment_display_arbiter;
    // 1 MHz x 1 ms keeps each dwell at 1000 cycles so the run stays short.
    localparam int D = 1000;

    typedef struct {
        int          cyc;
        logic [2:0]  g;
        logic [1:0]  o;
        logic [15:0] d;
    } exp_t;

    logic        clk50m_i = 1'b0;
    logic        rst_n_i  = 1'b1;
    logic [2:0]  req_i    = 3'b000;
    logic [15:0] data0_i  = 16'h1111;
    logic [15:0] data1_i  = 16'h2222;
    logic [15:0] data2_i  = 16'h3333;
    logic [2:0]  grant_o;
    logic [1:0]  owner_o;
    logic [15:0] hex_data_bus_o;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    logic [2:0]  pg;
    logic [1:0]  po;
    logic [15:0] pd;
    int   g;

    seven_segment_display_arbiter #(
        .CLK_FREQ_MHZ(1),
        .DWELL_MS(1),
        .IDLE_PATTERN(16'h0000)
    ) dut (
        .clk50m_i(clk50m_i),
        .rst_n_i(rst_n_i),
        .req_i(req_i),
        .data0_i(data0_i),
        .data1_i(data1_i),
        .data2_i(data2_i),
        .grant_o(grant_o),
        .owner_o(owner_o),
        .hex_data_bus_o(hex_data_bus_o)
    );

    always #10 clk50m_i = ~clk50m_i;
    always @(posedge clk50m_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int c, input logic [2:0] eg, input logic [1:0] eo, input logic [15:0] ed);
        q.push_back('{c, eg, eo, ed});
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk50m_i);
            #2;
        end
    endtask

    function automatic logic [1:0] owner_of(input logic [2:0] gv);
        return (gv == 3'b001) ? 2'd0 : (gv == 3'b010) ? 2'd1 : (gv == 3'b100) ? 2'd2 : 2'd3;
    endfunction

    // Monitor: every output change must match the next queued expectation,
    // including the clock edge on which it was predicted to happen.
    always @(negedge clk50m_i) begin
        if (mon_en) begin
            chk("invariant_onehot", {31'd0, grant_o inside {3'b000, 3'b001, 3'b010, 3'b100}}, 32'd1);
            chk("invariant_owner", {30'd0, owner_o}, {30'd0, owner_of(grant_o)});
            if ({grant_o, owner_o, hex_data_bus_o} !== {pg, po, pd}) begin
                if (q.size() == 0) begin
                    chk("unexpected_change", {11'd0, grant_o, owner_o, hex_data_bus_o}, {11'd0, pg, po, pd});
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("change_edge", cyc, e.cyc);
                    chk("grant", {29'd0, grant_o}, {29'd0, e.g});
                    chk("owner", {30'd0, owner_o}, {30'd0, e.o});
                    chk("hex_data", {16'd0, hex_data_bus_o}, {16'd0, e.d});
                end
                pg = grant_o;
                po = owner_o;
                pd = hex_data_bus_o;
            end
        end
    end

    initial begin
        #5 rst_n_i = 1'b0;
        step_to(3);
        rst_n_i = 1'b1;
        chk("reset_grant", {29'd0, grant_o}, 32'd0);
        chk("reset_owner", {30'd0, owner_o}, 32'd3);
        chk("reset_hex", {16'd0, hex_data_bus_o}, 32'h0000);
        pg = 3'b000;
        po = 2'd3;
        pd = 16'h0000;
        mon_en = 1'b1;

        // Idle for 100 cycles: any output change is flagged by the monitor.
        step_to(cyc + 100);

        // Single source 1: grant, live data, renewal without gap, frozen release.
        g = cyc + 1;
        req_i = 3'b010;
        expect_at(g, 3'b010, 2'd1, 16'h2222);
        step_to(g + 300);
        data1_i = 16'hABCD;
        expect_at(g + 301, 3'b010, 2'd1, 16'hABCD);
        step_to(g + 1500);
        req_i = 3'b000;
        step_to(g + 1600);
        data1_i = 16'h5555;
        expect_at(g + 2 * D, 3'b000, 2'd3, 16'h0000);
        step_to(g + 2 * D + 10);
        data1_i = 16'h2222;

        // Owner 0 releases early: output frozen, then idle at dwell expiry.
        g = cyc + 1;
        req_i = 3'b001;
        expect_at(g, 3'b001, 2'd0, 16'h1111);
        step_to(g + 200);
        data0_i = 16'h4444;
        expect_at(g + 201, 3'b001, 2'd0, 16'h4444);
        step_to(g + 400);
        req_i = 3'b000;
        step_to(g + 500);
        data0_i = 16'h7777;
        expect_at(g + D, 3'b000, 2'd3, 16'h0000);
        step_to(g + D + 10);
        data0_i = 16'h1111;

        // Late request from source 2 ten cycles before owner 1 expires.
        g = cyc + 1;
        req_i = 3'b010;
        expect_at(g, 3'b010, 2'd1, 16'h2222);
        step_to(g + D - 10);
        req_i = 3'b110;
        expect_at(g + D, 3'b100, 2'd2, 16'h3333);
        step_to(g + D + 100);
        req_i = 3'b000;
        expect_at(g + 2 * D, 3'b000, 2'd3, 16'h0000);
        step_to(g + 2 * D + 5);

        // Asynchronous reset mid-dwell, then round-robin 0,1,2,0 from reset.
        g = cyc + 1;
        req_i = 3'b001;
        expect_at(g, 3'b001, 2'd0, 16'h1111);
        step_to(g + 400);
        #1 rst_n_i = 1'b0;
        expect_at(cyc, 3'b000, 2'd3, 16'h0000);
        #1;
        chk("async_reset_grant", {29'd0, grant_o}, 32'd0);
        chk("async_reset_owner", {30'd0, owner_o}, 32'd3);
        chk("async_reset_hex", {16'd0, hex_data_bus_o}, 32'h0000);
        req_i = 3'b111;
        #4 rst_n_i = 1'b1;
        g = cyc + 1;
        expect_at(g, 3'b001, 2'd0, 16'h1111);
        expect_at(g + D, 3'b010, 2'd1, 16'h2222);
        expect_at(g + 2 * D, 3'b100, 2'd2, 16'h3333);
        expect_at(g + 3 * D, 3'b001, 2'd0, 16'h1111);
        step_to(g + 3 * D + 10);
        req_i = 3'b000;
        expect_at(g + 4 * D, 3'b000, 2'd3, 16'h0000);
        step_to(g + 4 * D + 10);

        chk("pending_expectations", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
